// File: rtl/framebuffer_pkg.sv
// framebuffer_pkg: shared fill-state encoding and default geometry for the framebuffer arbiter
package framebuffer_pkg;
    typedef enum logic [1:0] {IDLE, FILL, DONE} fill_state_e;
    localparam int DEFAULT_WIDTH = 9;
    localparam int DEFAULT_DEPTH = 2048;
    localparam int DEFAULT_GUARD = 4;
endpackage

// File: rtl/framebuffer_fill_engine.sv
// framebuffer_fill_engine: rectangle-fill sequencer walking a wrapping address range
// Ports: fill_start_i/fill_address_i/fill_length_i/fill_color_i/fill_abort_i command in;
//        grant_i = arbiter accepted this cycle's fill write; req_o = write wanted now;
//        active_o = FSM in FILL; addr_o/color_o = write address/data; busy_o, done_o status.
module framebuffer_fill_engine
    import framebuffer_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              fill_start_i,
    input  logic [ADDR_W-1:0] fill_address_i,
    input  logic [ADDR_W:0]   fill_length_i,
    input  logic [WIDTH-1:0]  fill_color_i,
    input  logic              fill_abort_i,
    input  logic              grant_i,
    output logic              req_o,
    output logic              active_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [WIDTH-1:0]  color_o,
    output logic              busy_o,
    output logic              done_o
);
    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [WIDTH-1:0]  color_q, color_d;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        color_d  = color_q;
        case (state_q)
            IDLE: if (fill_start_i && !fill_abort_i) begin
                addr_d   = fill_address_i;
                remain_d = fill_length_i;
                color_d  = fill_color_i;
                state_d  = (fill_length_i == '0) ? DONE : FILL;
            end
            FILL: if (fill_abort_i) begin
                state_d = IDLE;
            end else if (grant_i) begin
                // explicit wrap so non power-of-two depths stay in range
                addr_d   = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                remain_d = remain_q - 1'b1;
                state_d  = (remain_q == (ADDR_W + 1)'(1)) ? DONE : FILL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            color_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            color_q  <= color_d;
        end
    end

    // an abort cancels the write in the cycle it is raised
    assign active_o = (state_q == FILL);
    assign req_o    = active_o && !fill_abort_i;
    assign addr_o   = addr_q;
    assign color_o  = color_q;
    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE);
endmodule

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: shares framebuffer port A between a CPU and a fill engine
// Ports: cpuValid/cpuWrite/cpuAddress/cpuData request in, cpuReady accept (comb),
//        cpuReadValid/cpuReadData one cycle after an accepted read;
//        fillStart/fillAddress/fillLength/fillColor/fillAbort command in, fillBusy/fillDone status;
//        fbAddress/fbDataIn/fbWriteEnable drive port A, fbDataOut is its registered read data.
// Build option FRAMEBUFFER_STARVE_GUARD_EN: after GUARD consecutive CPU grants during a fill,
// one cycle is handed to the fill engine. Without it the CPU always wins.
module framebuffer_arbiter
    import framebuffer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int GUARD = DEFAULT_GUARD,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              cpuValid,
    input  logic              cpuWrite,
    input  logic [ADDR_W-1:0] cpuAddress,
    input  logic [WIDTH-1:0]  cpuData,
    output logic              cpuReady,
    output logic              cpuReadValid,
    output logic [WIDTH-1:0]  cpuReadData,
    input  logic              fillStart,
    input  logic [ADDR_W-1:0] fillAddress,
    input  logic [ADDR_W:0]   fillLength,
    input  logic [WIDTH-1:0]  fillColor,
    input  logic              fillAbort,
    output logic              fillBusy,
    output logic              fillDone,
    output logic [ADDR_W-1:0] fbAddress,
    output logic [WIDTH-1:0]  fbDataIn,
    output logic              fbWriteEnable,
    input  logic [WIDTH-1:0]  fbDataOut
);
    logic              cpu_grant, fill_grant, fill_req, fill_active, force_fill;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] fill_addr;
    logic [WIDTH-1:0]  fill_color;

    framebuffer_fill_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fill (
        .clk            (clk),
        .resetN         (resetN),
        .fill_start_i   (fillStart),
        .fill_address_i (fillAddress),
        .fill_length_i  (fillLength),
        .fill_color_i   (fillColor),
        .fill_abort_i   (fillAbort),
        .grant_i        (fill_grant),
        .req_o          (fill_req),
        .active_o       (fill_active),
        .addr_o         (fill_addr),
        .color_o        (fill_color),
        .busy_o         (fillBusy),
        .done_o         (fillDone)
    );

    // resetN gates the grant so port A is quiet the moment reset asserts
    assign cpu_grant     = resetN && cpuValid && !force_fill;
    assign fill_grant    = fill_req && !cpu_grant;
    assign cpuReady      = cpu_grant;
    assign fbWriteEnable = cpu_grant ? cpuWrite : fill_grant;
    assign fbAddress     = cpu_grant ? cpuAddress : (fill_grant ? fill_addr : '0);
    assign fbDataIn      = cpu_grant ? cpuData : (fill_grant ? fill_color : '0);

    assign rd_pend_d    = cpu_grant && !cpuWrite;
    assign cpuReadValid = rd_pend_q;
    assign cpuReadData  = rd_pend_q ? fbDataOut : '0;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) rd_pend_q <= 1'b0;
        else         rd_pend_q <= rd_pend_d;
    end

`ifdef FRAMEBUFFER_STARVE_GUARD_EN
    localparam int GW = $clog2(GUARD + 1);
    logic [GW-1:0] guard_q, guard_d;

    assign force_fill = fill_active && (guard_q == GW'(GUARD));
    assign guard_d    = (!fill_active || fill_grant) ? '0 : (cpu_grant ? guard_q + 1'b1 : guard_q);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) guard_q <= '0;
        else         guard_q <= guard_d;
    end
`else
    logic unused_guard;
    assign force_fill   = 1'b0;
    assign unused_guard = fill_active & (GUARD != 0);
`endif
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb_framebuffer_arbiter: directed self-checking bench for framebuffer_arbiter
module tb_framebuffer_arbiter;
    logic        clk = 0;
    logic        resetN;
    logic        cpuValid, cpuWrite, cpuReady, cpuReadValid;
    logic [10:0] cpuAddress;
    logic [8:0]  cpuData, cpuReadData;
    logic        fillStart, fillAbort, fillBusy, fillDone;
    logic [10:0] fillAddress;
    logic [11:0] fillLength;
    logic [8:0]  fillColor;
    logic [10:0] fbAddress;
    logic [8:0]  fbDataIn, fbDataOut;
    logic        fbWriteEnable;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int rv     = 0;
    int start_cyc;
    logic [10:0] wa[$];
    logic [8:0]  wd[$];
    int          wc[$];
    int          dc[$];
    logic [8:0]  mem [2048];

    framebuffer_arbiter dut (
        .clk(clk), .resetN(resetN),
        .cpuValid(cpuValid), .cpuWrite(cpuWrite), .cpuAddress(cpuAddress), .cpuData(cpuData),
        .cpuReady(cpuReady), .cpuReadValid(cpuReadValid), .cpuReadData(cpuReadData),
        .fillStart(fillStart), .fillAddress(fillAddress), .fillLength(fillLength),
        .fillColor(fillColor), .fillAbort(fillAbort), .fillBusy(fillBusy), .fillDone(fillDone),
        .fbAddress(fbAddress), .fbDataIn(fbDataIn), .fbWriteEnable(fbWriteEnable),
        .fbDataOut(fbDataOut)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fbWriteEnable) mem[fbAddress] <= fbDataIn;
        fbDataOut <= mem[fbAddress];
    end

    always @(negedge clk) begin
        if (fbWriteEnable) begin
            wa.push_back(fbAddress);
            wd.push_back(fbDataIn);
            wc.push_back(cyc);
        end
        if (fillDone) dc.push_back(cyc);
        if (cpuReadValid) rv++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_log();
        wa.delete(); wd.delete(); wc.delete(); dc.delete();
    endtask

    task automatic check_log(input string tag, input int n, input int base, input int color,
                             input int first, input int stride);
        check({tag, "_count"}, wa.size(), n);
        for (int i = 0; i < n && i < wa.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wa[i], (base + i) % 2048);
            check($sformatf("%s_data%0d", tag, i), wd[i], color);
            check($sformatf("%s_cyc%0d", tag, i), wc[i], first + i * stride);
        end
    endtask

    task automatic check_done(input string tag, input int n, input int at);
        check({tag, "_done_count"}, dc.size(), n);
        if (n > 0 && dc.size() > 0) check({tag, "_done_cyc"}, dc[0], at);
    endtask

    task automatic start_fill(input int a, input int len, input int color);
        clear_log();
        @(posedge clk); #1;
        fillStart = 1; fillAddress = 11'(a); fillLength = 12'(len); fillColor = 9'(color);
        @(negedge clk); start_cyc = cyc;
        @(posedge clk); #1;
        fillStart = 0;
    endtask

    initial begin
        resetN = 0; cpuValid = 1; cpuWrite = 1; cpuAddress = 5; cpuData = 9'h1A5;
        fillStart = 0; fillAddress = 0; fillLength = 0; fillColor = 0; fillAbort = 0;
        #3;
        check("rst_cpuReady", cpuReady, 0);
        check("rst_fbWriteEnable", fbWriteEnable, 0);
        check("rst_fbAddress", fbAddress, 0);
        check("rst_fillBusy", fillBusy, 0);
        check("rst_fillDone", fillDone, 0);
        check("rst_cpuReadValid", cpuReadValid, 0);
        check("rst_cpuReadData", cpuReadData, 0);
        cpuValid = 0;
        repeat (2) @(posedge clk);
        #1 resetN = 1;

        // CPU write then read of address 5
        @(posedge clk); #1;
        cpuValid = 1; cpuWrite = 1; cpuAddress = 5; cpuData = 9'h1A5;
        @(negedge clk);
        check("wr_cpuReady", cpuReady, 1);
        check("wr_fbWriteEnable", fbWriteEnable, 1);
        check("wr_fbAddress", fbAddress, 5);
        check("wr_fbDataIn", fbDataIn, 9'h1A5);
        @(posedge clk); #1;
        cpuWrite = 0;
        @(negedge clk);
        check("rd_cpuReady", cpuReady, 1);
        check("rd_fbWriteEnable", fbWriteEnable, 0);
        check("wr_no_readvalid", cpuReadValid, 0);
        @(posedge clk); #1;
        cpuValid = 0;
        @(negedge clk);
        check("rd_cpuReadValid", cpuReadValid, 1);
        check("rd_cpuReadData", cpuReadData, 9'h1A5);
        check("idle_fbWriteEnable", fbWriteEnable, 0);
        check("idle_fbAddress", fbAddress, 0);
        check("idle_fbDataIn", fbDataIn, 0);
        @(negedge clk);
        check("rd_valid_single", cpuReadValid, 0);

        // fill across the wrap point
        start_fill(2046, 4, 9'h0FF);
        @(negedge clk);
        check("wrap_busy", fillBusy, 1);
        repeat (7) @(negedge clk);
        check_log("wrap", 4, 2046, 9'h0FF, start_cyc + 1, 1);
        check_done("wrap", 1, start_cyc + 5);
        check("wrap_idle_busy", fillBusy, 0);

        // zero-length fill
        start_fill(0, 0, 9'h1FF);
        repeat (4) @(negedge clk);
        check_log("zero", 0, 0, 0, 0, 1);
        check_done("zero", 1, start_cyc + 1);

        // start while busy is ignored
        start_fill(100, 3, 9'h055);
        fillStart = 1; fillAddress = 500; fillLength = 7; fillColor = 9'h1FF;
        @(posedge clk); #1;
        fillStart = 0;
        repeat (8) @(negedge clk);
        check_log("busy", 3, 100, 9'h055, start_cyc + 1, 1);
        check_done("busy", 1, start_cyc + 4);

        // abort after three writes
        start_fill(10, 10, 9'h0AA);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        fillAbort = 1;
        @(negedge clk);
        check("abort_no_write", fbWriteEnable, 0);
        check("abort_busy_hold", fillBusy, 1);
        @(posedge clk); #1;
        fillAbort = 0;
        @(negedge clk);
        check("abort_busy_low", fillBusy, 0);
        repeat (12) @(negedge clk);
        check_log("abort", 3, 10, 9'h0AA, start_cyc + 1, 1);
        check_done("abort", 0, 0);

        // abort together with start in IDLE
        clear_log();
        @(posedge clk); #1;
        fillStart = 1; fillAbort = 1; fillAddress = 40; fillLength = 5; fillColor = 9'h123;
        @(posedge clk); #1;
        fillStart = 0; fillAbort = 0;
        @(negedge clk);
        check("abort_start_busy", fillBusy, 0);
        repeat (6) @(negedge clk);
        check_log("abort_start", 0, 0, 0, 0, 1);
        check_done("abort_start", 0, 0);

        // CPU reads held high during a fill
        clear_log();
        @(posedge clk); #1;
        cpuValid = 1; cpuWrite = 0; cpuAddress = 7;
        fillStart = 1; fillAddress = 300; fillLength = 3; fillColor = 9'h111;
        @(negedge clk); start_cyc = cyc;
        @(posedge clk); #1;
        fillStart = 0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
`ifdef FRAMEBUFFER_STARVE_GUARD_EN
            check($sformatf("starve_ready%0d", i), cpuReady, (i % 5) != 0);
`else
            check($sformatf("starve_ready%0d", i), cpuReady, 1);
`endif
        end
`ifndef FRAMEBUFFER_STARVE_GUARD_EN
        check("starve_no_fill", wa.size(), 0);
`endif
        @(posedge clk); #1;
        cpuValid = 0;
        repeat (8) @(negedge clk);
`ifdef FRAMEBUFFER_STARVE_GUARD_EN
        check_log("starve", 3, 300, 9'h111, start_cyc + 5, 5);
        check_done("starve", 1, start_cyc + 16);
`else
        check_log("starve", 3, 300, 9'h111, start_cyc + 16, 1);
        check_done("starve", 1, start_cyc + 19);
`endif

        // reset mid-fill with a read outstanding
        start_fill(20, 10, 9'h033);
        @(posedge clk); #1;
        cpuValid = 1; cpuWrite = 0; cpuAddress = 5;
        @(negedge clk);
        check("rstfill_read_accept", cpuReady, 1);
        @(posedge clk); #1;
        resetN = 0; cpuWrite = 1;
        #1;
        check("rstfill_cpuReady", cpuReady, 0);
        check("rstfill_cpuReadValid", cpuReadValid, 0);
        check("rstfill_cpuReadData", cpuReadData, 0);
        check("rstfill_fillBusy", fillBusy, 0);
        check("rstfill_fillDone", fillDone, 0);
        check("rstfill_fbWriteEnable", fbWriteEnable, 0);
        check("rstfill_fbAddress", fbAddress, 0);
        cpuValid = 0; cpuWrite = 0;
        clear_log();
        rv = 0;
        repeat (2) @(posedge clk);
        #1 resetN = 1;
        repeat (12) @(negedge clk);
        check_log("rstfill", 0, 0, 0, 0, 1);
        check_done("rstfill", 0, 0);
        check("rstfill_no_readvalid", rv, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
